// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions: funct codes and the HI/LO unit state encoding.
package mips_pkg;

    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        FINISH
    } hilo_state_t;

endpackage

// File: rtl/hi_lo_iteration_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on an
// accumulator/shift-register pair. Purely combinational.
module hi_lo_iteration_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] shreg,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] shreg_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum        = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : '0);
        rem_shift  = {acc, shreg[WIDTH-1]};
        ge         = rem_shift >= {1'b0, operand};
        // when ge holds the true difference fits in WIDTH bits
        diff       = rem_shift[WIDTH-1:0] - operand;
        acc_next   = '0;
        shreg_next = '0;
        if (is_div) begin
            acc_next   = ge ? diff : rem_shift[WIDTH-1:0];
            shreg_next = {shreg[WIDTH-2:0], ge};
        end else begin
            acc_next   = sum[WIDTH:1];
            shreg_next = {sum[0], shreg[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hi_lo_multiply_divide_unit.sv
// Execute-stage HI/LO unit: iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO,
// owning the architectural HI and LO registers.
module hi_lo_multiply_divide_unit
    import mips_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int COUNT_WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             instruction_valid,
    input  logic [5:0]       ALU_function,
    input  logic             HI_register_write,
    input  logic             LO_register_write,
    input  logic [WIDTH-1:0] operand_A,
    input  logic [WIDTH-1:0] operand_B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);

    hilo_state_t state_q, state_d;

    logic [COUNT_WIDTH-1:0] counter_q;
    logic [WIDTH-1:0]       acc_q, shreg_q, operand_q, dividend_q;
    logic [WIDTH-1:0]       acc_next, shreg_next;
    logic [WIDTH-1:0]       hi_q, lo_q;
    logic                   is_div_q, neg_q, neg_r_q, div_zero_q, done_q;

    logic                   start, mthi, mtlo, start_div, signed_op;
    logic [WIDTH-1:0]       mag_a, mag_b;
    logic [2*WIDTH-1:0]     product, product_fix;
    logic [WIDTH-1:0]       quotient_fix, remainder_fix;

    always_comb begin
        start = instruction_valid & HI_register_write & LO_register_write &
                ((ALU_function == FUNCT_MULT) | (ALU_function == FUNCT_MULTU) |
                 (ALU_function == FUNCT_DIV)  | (ALU_function == FUNCT_DIVU));
        mthi  = instruction_valid & HI_register_write & ~LO_register_write &
                (ALU_function == FUNCT_MTHI);
        mtlo  = instruction_valid & LO_register_write & ~HI_register_write &
                (ALU_function == FUNCT_MTLO);
        start_div = (ALU_function == FUNCT_DIV) | (ALU_function == FUNCT_DIVU);
        signed_op = (ALU_function == FUNCT_DIV) | (ALU_function == FUNCT_MULT);
        mag_a = (signed_op & operand_A[WIDTH-1]) ? -operand_A : operand_A;
        mag_b = (signed_op & operand_B[WIDTH-1]) ? -operand_B : operand_B;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start) state_d = start_div ? DIV : MULT;
            MULT,
            DIV:      if (counter_q == COUNT_WIDTH'(WIDTH - 1)) state_d = FINISH;
            FINISH:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    hi_lo_iteration_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div     (is_div_q),
        .acc        (acc_q),
        .shreg      (shreg_q),
        .operand    (operand_q),
        .acc_next   (acc_next),
        .shreg_next (shreg_next)
    );

    // sign fixup on magnitudes; a zero divisor bypasses it entirely
    always_comb begin
        product       = {acc_q, shreg_q};
        product_fix   = neg_q ? -product : product;
        quotient_fix  = neg_q ? -shreg_q : shreg_q;
        remainder_fix = neg_r_q ? -acc_q : acc_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            counter_q  <= '0;
            acc_q      <= '0;
            shreg_q    <= '0;
            operand_q  <= '0;
            dividend_q <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_r_q    <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        counter_q  <= '0;
                        acc_q      <= '0;
                        shreg_q    <= start_div ? mag_a : mag_b;
                        operand_q  <= start_div ? mag_b : mag_a;
                        dividend_q <= operand_A;
                        is_div_q   <= start_div;
                        neg_q      <= signed_op & (operand_A[WIDTH-1] ^ operand_B[WIDTH-1]);
                        neg_r_q    <= signed_op & operand_A[WIDTH-1];
                        div_zero_q <= (operand_B == '0);
                    end else if (mthi) begin
                        hi_q <= operand_A;
                    end else if (mtlo) begin
                        lo_q <= operand_A;
                    end
                end
                MULT,
                DIV: begin
                    acc_q     <= acc_next;
                    shreg_q   <= shreg_next;
                    counter_q <= counter_q + 1'b1;
                end
                FINISH: begin
                    done_q <= 1'b1;
                    if (!is_div_q) begin
                        hi_q <= product_fix[2*WIDTH-1:WIDTH];
                        lo_q <= product_fix[WIDTH-1:0];
                    end else if (div_zero_q) begin
                        hi_q <= dividend_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= remainder_fix;
                        lo_q <= quotient_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_hi_lo_multiply_divide_unit.sv
// Directed-vector bench for the HI/LO multiply/divide unit.
module tb_hi_lo_multiply_divide_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instruction_valid = 1'b0;
    logic [5:0]  ALU_function = '0;
    logic        HI_register_write = 1'b0;
    logic        LO_register_write = 1'b0;
    logic [31:0] operand_A = '0;
    logic [31:0] operand_B = '0;
    logic [31:0] HI, LO;
    logic        busy, done;

    int total = 0;
    int bad   = 0;
    int cyc, bcnt;

    hi_lo_multiply_divide_unit dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .instruction_valid (instruction_valid),
        .ALU_function      (ALU_function),
        .HI_register_write (HI_register_write),
        .LO_register_write (LO_register_write),
        .operand_A         (operand_A),
        .operand_B         (operand_B),
        .HI                (HI),
        .LO                (LO),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] f, input logic hw,
                         input logic lw, input logic [31:0] a,
                         input logic [31:0] b);
        instruction_valid = v;
        ALU_function      = f;
        HI_register_write = hw;
        LO_register_write = lw;
        operand_A         = a;
        operand_B         = b;
    endtask

    // present op for one cycle, then wait (bounded) for done
    task automatic run_op(input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, output int c, output int bc);
        @(negedge clk);
        drive(1'b1, f, 1'b1, 1'b1, a, b);
        @(posedge clk);
        #1;
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        c  = 1;
        bc = 0;
        while (!done && c < 100) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op(FUNCT_MULT, 32'hFFFFFFFF, 32'h00000002, cyc, bcnt);
        check("mult_latency", cyc, 34);
        check("mult_busy_cycles", bcnt, 33);
        check("mult_hi", HI, 32'hFFFFFFFF);
        check("mult_lo", LO, 32'hFFFFFFFE);
        check("mult_busy_at_done", busy, 0);
        @(posedge clk);
        #1;
        check("done_pulse_one", done, 0);

        run_op(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, bcnt);
        check("multu_hilo", {HI, LO}, 64'hFFFFFFFE_00000001);

        run_op(FUNCT_DIV, 32'hFFFFFFF9, 32'd2, cyc, bcnt);
        check("div_neg_latency", cyc, 34);
        check("div_neg_hilo", {HI, LO}, {32'hFFFFFFFF, 32'hFFFFFFFD});

        run_op(FUNCT_DIVU, 32'd7, 32'd2, cyc, bcnt);
        check("divu_hilo", {HI, LO}, {32'd1, 32'd3});

        run_op(FUNCT_DIVU, 32'h1234, 32'd0, cyc, bcnt);
        check("divu_zero_latency", cyc, 34);
        check("divu_zero_hilo", {HI, LO}, {32'h1234, 32'hFFFFFFFF});

        run_op(FUNCT_DIV, 32'hFFFFFFF9, 32'd0, cyc, bcnt);
        check("div_zero_hilo", {HI, LO}, {32'hFFFFFFF9, 32'hFFFFFFFF});

        run_op(FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF, cyc, bcnt);
        check("div_ovf_hilo", {HI, LO}, {32'h0, 32'h80000000});

        run_op(FUNCT_MULT, 32'hFFFFFFFD, 32'd5, cyc, bcnt);
        check("mult_neg_pos", {HI, LO}, 64'hFFFFFFFF_FFFFFFF1);

        // back-to-back MTHI then MTLO
        @(negedge clk);
        drive(1'b1, FUNCT_MTHI, 1'b1, 1'b0, 32'h12345678, '0);
        @(posedge clk);
        #1;
        check("mthi_hi", HI, 32'h12345678);
        check("mthi_lo_kept", LO, 32'hFFFFFFF1);
        drive(1'b1, FUNCT_MTLO, 1'b0, 1'b1, 32'h9ABCDEF0, '0);
        @(posedge clk);
        #1;
        check("mtlo_lo", LO, 32'h9ABCDEF0);
        check("mtlo_hi_kept", HI, 32'h12345678);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);

        // bubble with write enables must not write
        @(negedge clk);
        drive(1'b0, FUNCT_MTHI, 1'b1, 1'b0, 32'hBAD0BAD0, '0);
        @(posedge clk);
        #1;
        check("bubble_hi", HI, 32'h12345678);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);

        // MTHI/MTLO/start while busy are ignored
        @(negedge clk);
        drive(1'b1, FUNCT_MULTU, 1'b1, 1'b1, 32'd3, 32'd5);
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
        drive(1'b1, FUNCT_MTHI, 1'b1, 1'b0, 32'hDEADBEEF, '0);
        @(posedge clk);
        #1;
        check("busy_mthi_hi", HI, 32'h12345678);
        drive(1'b1, FUNCT_MTLO, 1'b0, 1'b1, 32'hCAFEF00D, '0);
        @(posedge clk);
        #1;
        check("busy_mtlo_lo", LO, 32'h9ABCDEF0);
        drive(1'b1, FUNCT_DIVU, 1'b1, 1'b1, 32'd100, 32'd7);
        @(posedge clk);
        #1;
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("busy_wait_bound", cyc < 100, 1);
        check("busy_mult_result", {HI, LO}, 64'd15);

        // asynchronous reset in the middle of a DIV
        @(negedge clk);
        drive(1'b1, FUNCT_DIV, 1'b1, 1'b1, 32'd1000, 32'd3);
        @(posedge clk);
        #1;
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        repeat (10) @(posedge clk);
        #2;
        check("pre_rst_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("arst_hi", HI, 0);
        check("arst_lo", LO, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(FUNCT_MULT, 32'd6, 32'd7, cyc, bcnt);
        check("post_rst_latency", cyc, 34);
        check("post_rst_hilo", {HI, LO}, 64'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
